// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, looked up from IF.
// Optional BP_STATS_EN adds lookup and mispredict counters.
module branch_predictor #(
    parameter  int ADDR_W  = 32,
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = ADDR_W - 2 - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] jmp_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             unused;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);

    // Low PC bits are always zero for aligned fetches.
    assign unused = ^{if_pc[1:0], upd_pc[1:0], if_valid, upd_mispredict};

    // Zero-latency lookup; no bypass from a same-cycle update.
    assign pred_hit    = valid[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken  = pred_hit && (jmp_q[l_idx] || ctr_q[l_idx][1]);
    assign pred_target = pred_taken ? tgt_q[l_idx] : if_pc + FOUR;

    // Valid bits: reset, flash-invalidate, or set on taken-miss allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (upd_valid && !u_hit && upd_taken) begin
            valid[u_idx] <= 1'b1;
        end
    end

    // Entry payload; meaningless while invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_valid && !inv_all) begin
            if (u_hit) begin
                jmp_q[u_idx] <= upd_is_jump;
                if (upd_taken) begin
                    tgt_q[u_idx] <= upd_target;
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                    end
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                tag_q[u_idx] <= u_tag;
                tgt_q[u_idx] <= upd_target;
                jmp_q[u_idx] <= upd_is_jump;
                ctr_q[u_idx] <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    // Saturating event counters; inv_all leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (if_valid && stat_lookups != '1) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (upd_valid && upd_mispredict && stat_mispredicts != '1) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; lookups checked by a
// scoreboard monitor on the falling edge.
module tb_branch_predictor;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        inv_all;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    logic chk;
    exp_t q[$];
    int   checks;
    int   errors;

    branch_predictor #(.ADDR_W(32), .ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_is_jump    (upd_is_jump),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv_all        (inv_all)
`ifdef BP_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [33:0] act,
                         input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: compare the combinational lookup against the queue.
    always @(negedge clk) begin
        if (chk) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lookup got unexpected want none");
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("lookup_pc_%h", if_pc),
                      {pred_hit, pred_taken, pred_target}, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chk            = 1'b0;
        if_valid       = 1'b0;
        upd_valid      = 1'b0;
        upd_taken      = 1'b0;
        upd_is_jump    = 1'b0;
        upd_mispredict = 1'b0;
        inv_all        = 1'b0;
    endtask

    task automatic lk(input logic [31:0] pc, input logic h,
                      input logic t, input logic [31:0] tg);
        exp_t e;
        e.hit   = h;
        e.taken = t;
        e.tgt   = tg;
        if_pc   = pc;
        chk     = 1'b1;
        q.push_back(e);
    endtask

    task automatic up(input logic [31:0] pc, input logic tk,
                      input logic j, input logic [31:0] tg);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_is_jump = j;
        upd_target  = tg;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        chk = 1'b0;
        if_valid = 1'b0;
        if_pc = 32'h0;
        upd_valid = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;
        upd_is_jump = 1'b0;
        upd_target = 32'h0;
        upd_mispredict = 1'b0;
        inv_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state, then train 0x40 and walk the counter
        lk(32'h40, 0, 0, 32'h44); up(32'h40, 1, 0, 32'h100);
        cyc(); lk(32'h40, 1, 1, 32'h100); up(32'h40, 0, 0, 32'h0);
        cyc(); lk(32'h40, 1, 0, 32'h44);  up(32'h40, 0, 0, 32'h0);
        cyc(); lk(32'h40, 1, 0, 32'h44);  up(32'h40, 0, 0, 32'h0);
        cyc(); lk(32'h40, 1, 0, 32'h44);  up(32'h40, 1, 0, 32'h104);
        cyc(); lk(32'h40, 1, 0, 32'h44);  up(32'h40, 1, 0, 32'h100);
        cyc(); lk(32'h40, 1, 1, 32'h100); up(32'h40, 1, 0, 32'h100);
        cyc(); lk(32'h40, 1, 1, 32'h100); up(32'h40, 1, 0, 32'h100);
        cyc(); lk(32'h40, 1, 1, 32'h100); up(32'h40, 0, 0, 32'h0);
        cyc(); lk(32'h40, 1, 1, 32'h100);

        // Aliasing at index 0
        cyc(); lk(32'h80, 0, 0, 32'h84); up(32'h80, 1, 0, 32'h200);
        cyc(); lk(32'h40, 0, 0, 32'h44);
        cyc(); lk(32'h80, 1, 1, 32'h200);

        // Jump entry keeps predicting taken at ctr=0
        cyc(); lk(32'h10, 0, 0, 32'h14);  up(32'h10, 1, 1, 32'h300);
        cyc(); lk(32'h10, 1, 1, 32'h300); up(32'h10, 0, 1, 32'h0);
        cyc(); lk(32'h10, 1, 1, 32'h300); up(32'h10, 0, 1, 32'h0);
        cyc(); lk(32'h10, 1, 1, 32'h300); up(32'h10, 0, 1, 32'h0);
        cyc(); lk(32'h10, 1, 1, 32'h300); up(32'h10, 0, 0, 32'h0);
        cyc(); lk(32'h10, 1, 0, 32'h14);

        // Same-cycle lookup sees pre-update contents
        cyc(); lk(32'h24, 0, 0, 32'h28);  up(32'h24, 1, 0, 32'h400);
        cyc(); lk(32'h24, 1, 1, 32'h400); up(32'h34, 1, 0, 32'h500);
        inv_all = 1'b1;
        cyc(); lk(32'h24, 0, 0, 32'h28);
        cyc(); lk(32'h34, 0, 0, 32'h38);
        cyc(); lk(32'h80, 0, 0, 32'h84);
        cyc(); lk(32'hFFFF_FFFC, 0, 0, 32'h0);

        // Not-taken miss never allocates
        cyc(); up(32'h60, 0, 0, 32'h700);
        cyc(); lk(32'h60, 0, 0, 32'h64);

        // Reset during an update discards it
        cyc(); lk(32'h44, 0, 0, 32'h48); up(32'h44, 1, 0, 32'h600);
        #2 rst = 1'b0;
        cyc(); rst = 1'b1; lk(32'h44, 0, 0, 32'h48);
        cyc(); lk(32'h44, 0, 0, 32'h48);

`ifdef BP_STATS_EN
        cyc(); if_valid = 1'b1;
        cyc(); if_valid = 1'b1; up(32'h8, 0, 0, 32'h0); upd_mispredict = 1'b1;
        cyc(); if_valid = 1'b1; upd_mispredict = 1'b1;
        cyc(); if_valid = 1'b1; up(32'h8, 0, 0, 32'h0); upd_mispredict = 1'b1;
        cyc(); if_valid = 1'b1; up(32'h8, 0, 0, 32'h0);
        cyc(); inv_all = 1'b1;
        cyc();
        check("stat_lookups", {2'b00, stat_lookups}, {2'b00, 32'd5});
        check("stat_mispredicts", {2'b00, stat_mispredicts}, {2'b00, 32'd2});
        rst = 1'b0;
        #1;
        check("stat_lookups_rst", {2'b00, stat_lookups}, 34'd0);
        check("stat_mispredicts_rst", {2'b00, stat_mispredicts}, 34'd0);
        rst = 1'b1;
`endif

        cyc();
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard got %0d left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
